// File: rtl/lcd_spi_capture.sv
// Receive side of the 4-wire LCD SPI link: oversampled deserializer plus
// window/RAMWR decoder that emits one strobe per RGB565 pixel.
module lcd_spi_capture #(
    parameter int LCD_W = 132,
    parameter int LCD_H = 162
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_cs_n_in,
    input  logic        lcd_clk_in,
    input  logic        lcd_data_in,
    input  logic        lcd_dc_in,
    input  logic        lcd_rst_n_in,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_done
);

    localparam logic [7:0] X_MAX = 8'(LCD_W - 1);
    localparam logic [7:0] Y_MAX = 8'(LCD_H - 1);

    typedef enum logic [2:0] {
        IDLE, CASET_ARG, RASET_ARG, RAMWR_HI, RAMWR_LO
    } state_t;

    logic [1:0] cs_s, scl_s, sda_s, dc_s, rn_s;
    logic       scl_d;
    logic       scl_rise, soft_rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_s  <= 2'b11;
            scl_s <= 2'b00;
            sda_s <= 2'b00;
            dc_s  <= 2'b00;
            rn_s  <= 2'b11;
            scl_d <= 1'b0;
        end else begin
            cs_s  <= {cs_s[0], lcd_cs_n_in};
            scl_s <= {scl_s[0], lcd_clk_in};
            sda_s <= {sda_s[0], lcd_data_in};
            dc_s  <= {dc_s[0], lcd_dc_in};
            rn_s  <= {rn_s[0], lcd_rst_n_in};
            scl_d <= scl_s[1];
        end
    end

    assign scl_rise = scl_s[1] & ~scl_d;
    assign soft_rst = ~rn_s[1];

    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       byte_stb;
    logic [7:0] byte_val;
    logic       byte_dc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            byte_stb <= 1'b0;
            byte_val <= 8'h00;
            byte_dc  <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            if (soft_rst || cs_s[1]) begin
                bit_cnt <= 3'd0;
            end else if (scl_rise) begin
                shreg   <= {shreg[6:0], sda_s[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_stb <= 1'b1;
                    byte_val <= {shreg[6:0], sda_s[1]};
                    byte_dc  <= dc_s[1];
                end
            end
        end
    end

    state_t      state, state_nx;
    logic [1:0]  arg_cnt, arg_cnt_nx;
    logic [7:0]  arg_lo, arg_lo_nx;
    logic [7:0]  xs, xe, ys, ye, xs_nx, xe_nx, ys_nx, ye_nx;
    logic [7:0]  x, y, x_nx, y_nx;
    logic [7:0]  hi, hi_nx, win_end;
    logic        cmd_valid_nx, pix_valid_nx, frame_done_nx;
    logic [7:0]  cmd_byte_nx, pix_x_nx, pix_y_nx;
    logic [15:0] pix_data_nx;

    assign win_end = (byte_val < arg_lo) ? arg_lo : byte_val;

    always_comb begin
        state_nx      = state;
        arg_cnt_nx    = arg_cnt;
        arg_lo_nx     = arg_lo;
        xs_nx         = xs;
        xe_nx         = xe;
        ys_nx         = ys;
        ye_nx         = ye;
        x_nx          = x;
        y_nx          = y;
        hi_nx         = hi;
        cmd_valid_nx  = 1'b0;
        cmd_byte_nx   = cmd_byte;
        pix_valid_nx  = 1'b0;
        pix_x_nx      = pix_x;
        pix_y_nx      = pix_y;
        pix_data_nx   = pix_data;
        frame_done_nx = 1'b0;
        if (soft_rst) begin
            state_nx    = IDLE;
            arg_cnt_nx  = 2'd0;
            xs_nx       = 8'd0;
            xe_nx       = X_MAX;
            ys_nx       = 8'd0;
            ye_nx       = Y_MAX;
            x_nx        = 8'd0;
            y_nx        = 8'd0;
            cmd_byte_nx = 8'h00;
            pix_x_nx    = 8'd0;
            pix_y_nx    = 8'd0;
            pix_data_nx = 16'h0000;
        end else if (byte_stb && !byte_dc) begin
            cmd_valid_nx = 1'b1;
            cmd_byte_nx  = byte_val;
            arg_cnt_nx   = 2'd0;
            unique case (1'b1)
                byte_val == 8'h2A: state_nx = CASET_ARG;
                byte_val == 8'h2B: state_nx = RASET_ARG;
                byte_val == 8'h2C: begin
                    state_nx = RAMWR_HI;
                    x_nx     = xs;
                    y_nx     = ys;
                end
                default: state_nx = IDLE;
            endcase
        end else if (byte_stb) begin
            unique case (state)
                CASET_ARG, RASET_ARG: begin
                    arg_cnt_nx = arg_cnt + 2'd1;
                    if (arg_cnt == 2'd1) arg_lo_nx = byte_val;
                    if (arg_cnt == 2'd3) begin
                        state_nx = IDLE;
                        if (state == CASET_ARG) begin
                            xs_nx = arg_lo;
                            xe_nx = win_end;
                        end else begin
                            ys_nx = arg_lo;
                            ye_nx = win_end;
                        end
                    end
                end
                RAMWR_HI: begin
                    hi_nx    = byte_val;
                    state_nx = RAMWR_LO;
                end
                RAMWR_LO: begin
                    pix_valid_nx  = 1'b1;
                    pix_x_nx      = x;
                    pix_y_nx      = y;
                    pix_data_nx   = {hi, byte_val};
                    frame_done_nx = (x == xe) && (y == ye);
                    state_nx      = RAMWR_HI;
                    if (x < xe) begin
                        x_nx = x + 8'd1;
                    end else begin
                        x_nx = xs;
                        y_nx = (y == ye) ? ys : y + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            arg_cnt    <= 2'd0;
            arg_lo     <= 8'd0;
            xs         <= 8'd0;
            xe         <= X_MAX;
            ys         <= 8'd0;
            ye         <= Y_MAX;
            x          <= 8'd0;
            y          <= 8'd0;
            hi         <= 8'd0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'h00;
            pix_valid  <= 1'b0;
            pix_x      <= 8'd0;
            pix_y      <= 8'd0;
            pix_data   <= 16'h0000;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            arg_cnt    <= arg_cnt_nx;
            arg_lo     <= arg_lo_nx;
            xs         <= xs_nx;
            xe         <= xe_nx;
            ys         <= ys_nx;
            ye         <= ye_nx;
            x          <= x_nx;
            y          <= y_nx;
            hi         <= hi_nx;
            cmd_valid  <= cmd_valid_nx;
            cmd_byte   <= cmd_byte_nx;
            pix_valid  <= pix_valid_nx;
            pix_x      <= pix_x_nx;
            pix_y      <= pix_y_nx;
            pix_data   <= pix_data_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_lcd_spi_capture.sv
// Directed bench for lcd_spi_capture: drives the SPI pins at clk/4 and
// checks logged command/pixel strobes against hand-computed values.
module tb_lcd_spi_capture;

    logic        clk;
    logic        rst;
    logic        lcd_cs_n_in;
    logic        lcd_clk_in;
    logic        lcd_data_in;
    logic        lcd_dc_in;
    logic        lcd_rst_n_in;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] pix_data;
    logic        frame_done;

    lcd_spi_capture dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_cs_n_in  (lcd_cs_n_in),
        .lcd_clk_in   (lcd_clk_in),
        .lcd_data_in  (lcd_data_in),
        .lcd_dc_in    (lcd_dc_in),
        .lcd_rst_n_in (lcd_rst_n_in),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_data     (pix_data),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] d;
        logic        fd;
    } pix_t;

    pix_t       pix_q[$];
    logic [7:0] cmd_q[$];
    int         stray_fd = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always @(negedge clk) begin
        if (cmd_valid) cmd_q.push_back(cmd_byte);
        if (pix_valid) pix_q.push_back('{pix_x, pix_y, pix_data, frame_done});
        if (frame_done && !pix_valid) stray_fd++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic dc, input logic b);
        lcd_clk_in  = 1'b0;
        lcd_data_in = b;
        lcd_dc_in   = dc;
        idle(2);
        lcd_clk_in = 1'b1;
        idle(2);
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        lcd_cs_n_in = 1'b0;
        for (int i = 7; i >= 0; i--) bit_out(dc, b[i]);
        lcd_clk_in = 1'b0;
    endtask

    task automatic check_pix(input string tag, input int idx,
                             input logic [7:0] ex, input logic [7:0] ey,
                             input logic [15:0] ed, input logic efd);
        if (idx < pix_q.size()) begin
            check({tag, "_x"}, 32'(pix_q[idx].x), 32'(ex));
            check({tag, "_y"}, 32'(pix_q[idx].y), 32'(ey));
            check({tag, "_d"}, 32'(pix_q[idx].d), 32'(ed));
            check({tag, "_fd"}, 32'(pix_q[idx].fd), 32'(efd));
        end else begin
            check({tag, "_missing"}, 32'(pix_q.size()), 32'(idx + 1));
        end
    endtask

    int pb, cb;

    initial begin
        rst          = 1'b0;
        lcd_cs_n_in  = 1'b1;
        lcd_clk_in   = 1'b0;
        lcd_data_in  = 1'b0;
        lcd_dc_in    = 1'b0;
        lcd_rst_n_in = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(6);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_cmd_byte", 32'(cmd_byte), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_pix_x", 32'(pix_x), 0);
        check("rst_pix_y", 32'(pix_y), 0);
        check("rst_pix_data", 32'(pix_data), 0);
        check("rst_frame_done", 32'(frame_done), 0);

        // single pixel at origin
        send_byte(1'b0, 8'h2C);
        idle(8);
        check("t1_cmd_n", 32'(cmd_q.size()), 1);
        check("t1_cmd_byte", 32'(cmd_byte), 32'h2C);
        send_byte(1'b1, 8'hF8);
        send_byte(1'b1, 8'h00);
        idle(8);
        check("t1_pix_n", 32'(pix_q.size()), 1);
        check_pix("t1_p0", 0, 8'd0, 8'd0, 16'hF800, 1'b0);

        // 2x2 window with wrap
        pb = pix_q.size();
        cb = cmd_q.size();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h02);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h03);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h06);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send_byte(1'b1, 8'h10 + 8'(i));
            send_byte(1'b1, 8'h20 + 8'(i));
        end
        lcd_cs_n_in = 1'b1;
        idle(8);
        check("t2_cmd_n", 32'(cmd_q.size() - cb), 3);
        check("t2_pix_n", 32'(pix_q.size() - pb), 5);
        check_pix("t2_p0", pb + 0, 8'd2, 8'd5, 16'h1020, 1'b0);
        check_pix("t2_p1", pb + 1, 8'd3, 8'd5, 16'h1121, 1'b0);
        check_pix("t2_p2", pb + 2, 8'd2, 8'd6, 16'h1222, 1'b0);
        check_pix("t2_p3", pb + 3, 8'd3, 8'd6, 16'h1323, 1'b1);
        check_pix("t2_p4", pb + 4, 8'd2, 8'd5, 16'h1424, 1'b0);

        // partial byte discarded by CS high
        cb = cmd_q.size();
        lcd_cs_n_in = 1'b0;
        bit_out(1'b0, 1'b1);
        bit_out(1'b0, 1'b0);
        bit_out(1'b0, 1'b1);
        bit_out(1'b0, 1'b1);
        bit_out(1'b0, 1'b1);
        lcd_clk_in  = 1'b0;
        lcd_cs_n_in = 1'b1;
        idle(6);
        send_byte(1'b0, 8'h2C);
        lcd_cs_n_in = 1'b1;
        idle(8);
        check("t3_cmd_n", 32'(cmd_q.size() - cb), 1);
        check("t3_cmd_byte", 32'(cmd_byte), 32'h2C);

        // soft reset after high byte
        pb = pix_q.size();
        send_byte(1'b1, 8'hAB);
        lcd_cs_n_in  = 1'b1;
        idle(2);
        lcd_rst_n_in = 1'b0;
        idle(5);
        check("t4_pix_x_clr", 32'(pix_x), 0);
        check("t4_pix_y_clr", 32'(pix_y), 0);
        check("t4_pix_data_clr", 32'(pix_data), 0);
        check("t4_cmd_byte_clr", 32'(cmd_byte), 0);
        lcd_rst_n_in = 1'b1;
        idle(5);
        send_byte(1'b1, 8'hCD);
        send_byte(1'b1, 8'hEF);
        lcd_cs_n_in = 1'b1;
        idle(8);
        check("t4_no_pix", 32'(pix_q.size() - pb), 0);

        // truncated CASET keeps default window
        pb = pix_q.size();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h09);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h34);
        // start > end collapses to single column x=9
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h09);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h04);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h56);
        send_byte(1'b1, 8'h78);
        send_byte(1'b1, 8'h9A);
        send_byte(1'b1, 8'hBC);
        lcd_cs_n_in = 1'b1;
        idle(8);
        check("t5_pix_n", 32'(pix_q.size() - pb), 3);
        check_pix("t5_p0", pb + 0, 8'd0, 8'd0, 16'h1234, 1'b0);
        check_pix("t5_p1", pb + 1, 8'd9, 8'd0, 16'h5678, 1'b0);
        check_pix("t5_p2", pb + 2, 8'd9, 8'd1, 16'h9ABC, 1'b0);

        // async reset mid-byte
        lcd_cs_n_in = 1'b0;
        bit_out(1'b0, 1'b0);
        bit_out(1'b0, 1'b1);
        bit_out(1'b0, 1'b0);
        bit_out(1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t6_cmd_byte_async", 32'(cmd_byte), 0);
        check("t6_pix_x_async", 32'(pix_x), 0);
        check("t6_pix_y_async", 32'(pix_y), 0);
        check("t6_pix_data_async", 32'(pix_data), 0);
        @(negedge clk);
        lcd_clk_in  = 1'b0;
        lcd_cs_n_in = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(4);
        cb = cmd_q.size();
        send_byte(1'b0, 8'h2C);
        lcd_cs_n_in = 1'b1;
        idle(8);
        check("t6_cmd_n", 32'(cmd_q.size() - cb), 1);
        check("t6_cmd_byte", 32'(cmd_byte), 32'h2C);
        check("stray_frame_done", 32'(stray_fd), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
